// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM peripheral: ramp FSM states, period-end value
// and the peripheral register map.
package pwm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } ramp_state_t;

    localparam int PWM_WIDTH_DEFAULT = 8;

    // Counter value marking the last cycle of a PWM period at the default width
    localparam logic [PWM_WIDTH_DEFAULT-1:0] PWM_PERIOD_END = '1;

    localparam logic [7:0] PWM_CTRL_R   = 8'h00;
    localparam logic [7:0] PWM_C_R      = 8'h04;
    localparam logic [7:0] PWM_TARGET_R = 8'h08;
    localparam logic [7:0] PWM_STEP_R   = 8'h0C;
    localparam logic [7:0] PWM_DIV_R    = 8'h10;
    localparam logic [7:0] PWM_STATUS_R = 8'h14;

endpackage

// File: rtl/pwm_step_calc.sv
// Combinational next-compare calculation: moves current toward target by step,
// saturating at target so the compare value can never overshoot or wrap.
module pwm_step_calc #(
    parameter int pwm_width = 8
) (
    input  logic [pwm_width-1:0] current,
    input  logic [pwm_width-1:0] target,
    input  logic [pwm_width-1:0] step,
    output logic [pwm_width-1:0] next_value,
    output logic                 reached
);

    logic                 up;
    logic [pwm_width:0]   distance;
    logic                 snap;

    // The distance test is done one bit wider so the saturation choice is exact;
    // the plain add/subtract is only selected when it cannot leave the range.
    always_comb begin
        up       = target > current;
        distance = up ? ({1'b0, target} - {1'b0, current})
                      : ({1'b0, current} - {1'b0, target});
        snap     = (step == '0) || (distance <= {1'b0, step});

        if (snap) begin
            next_value = target;
        end else if (up) begin
            next_value = current + step;
        end else begin
            next_value = current - step;
        end

        reached = (next_value == target);
    end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Duty-cycle ramp sequencer: walks the PWM compare value toward a programmed
// target, one step per (div+1) PWM periods, updating only at period ends.
module pwm_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int pwm_width = 8,
    parameter int div_width = 8
) (
    input  logic                 pwm_clk,
    input  logic                 pwm_resetn,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [pwm_width-1:0] cfg_target,
    input  logic [pwm_width-1:0] cfg_step,
    input  logic [div_width-1:0] cfg_div,
    input  logic                 abort,
    input  logic [pwm_width-1:0] pwm_i,
    output logic [pwm_width-1:0] pwm_c,
    output logic                 busy,
    output logic                 done
);

    localparam logic [pwm_width-1:0] period_end = '1;

    ramp_state_t          state;
    logic [pwm_width-1:0] target_r;
    logic [pwm_width-1:0] step_r;
    logic [div_width-1:0] div_r;
    logic [div_width-1:0] div_cnt;
    logic [pwm_width-1:0] next_value;
    logic                 reached;
    logic                 at_period_end;

    assign cfg_ready     = (state == IDLE);
    assign busy          = (state == RAMP);
    assign at_period_end = (pwm_i == period_end);

    pwm_step_calc #(
        .pwm_width (pwm_width)
    ) u_step_calc (
        .current    (pwm_c),
        .target     (target_r),
        .step       (step_r),
        .next_value (next_value),
        .reached    (reached)
    );

    // Abort has priority over a pending update, so a stopped ramp never takes
    // one last step on the period end where it was aborted.
    always_ff @(posedge pwm_clk or negedge pwm_resetn) begin
        if (!pwm_resetn) begin
            state    <= IDLE;
            pwm_c    <= '0;
            div_cnt  <= '0;
            target_r <= '0;
            step_r   <= '0;
            div_r    <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        target_r <= cfg_target;
                        step_r   <= cfg_step;
                        div_r    <= cfg_div;
                        div_cnt  <= cfg_div;
                        if (cfg_target == pwm_c) begin
                            done <= 1'b1;
                        end else begin
                            state <= RAMP;
                        end
                    end
                end
                RAMP: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (at_period_end) begin
                        if (div_cnt != '0) begin
                            div_cnt <= div_cnt - 1'b1;
                        end else begin
                            pwm_c   <= next_value;
                            div_cnt <= div_r;
                            if (reached) begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: a period-level reference model checked every cycle,
// directed ramps pinned with literal expectations, then randomized ramps.
module tb_pwm_ramp_ctrl;

    logic       pwm_clk    = 1'b0;
    logic       pwm_resetn = 1'b0;
    logic       cfg_valid  = 1'b0;
    logic [7:0] cfg_target = '0;
    logic [7:0] cfg_step   = '0;
    logic [7:0] cfg_div    = '0;
    logic       abort      = 1'b0;
    logic [7:0] pwm_i      = '0;
    logic       cfg_ready;
    logic [7:0] pwm_c;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    bit m_ramp = 0;
    bit m_done = 0;
    int m_c    = 0;
    int m_tgt  = 0;
    int m_step = 0;
    int m_div  = 0;
    int m_wait = 0;

    int done_cnt = 0;
    int prev_c   = 0;
    int chg_val[$];
    int chg_time[$];

    pwm_ramp_ctrl #(
        .pwm_width (8),
        .div_width (8)
    ) dut (
        .pwm_clk    (pwm_clk),
        .pwm_resetn (pwm_resetn),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_target (cfg_target),
        .cfg_step   (cfg_step),
        .cfg_div    (cfg_div),
        .abort      (abort),
        .pwm_i      (pwm_i),
        .pwm_c      (pwm_c),
        .busy       (busy),
        .done       (done)
    );

    initial forever #5 pwm_clk = ~pwm_clk;

    initial forever begin
        @(negedge pwm_clk);
        pwm_i = pwm_i + 8'd1;
    end

    task automatic check_output(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Reference model: a ramp is a target, a step size, and a count of period
    // ends still to wait before the next move; moves saturate at the target.
    initial forever begin
        @(posedge pwm_clk);
        cycle++;
        m_done = 0;
        if (!pwm_resetn) begin
            m_ramp = 0;
            m_c    = 0;
            m_wait = 0;
        end else if (!m_ramp) begin
            if (cfg_valid) begin
                m_tgt  = cfg_target;
                m_step = cfg_step;
                m_div  = cfg_div;
                m_wait = m_div;
                if (m_tgt == m_c) m_done = 1;
                else              m_ramp = 1;
            end
        end else if (abort) begin
            m_ramp = 0;
        end else if (pwm_i == 8'hFF) begin
            if (m_wait > 0) begin
                m_wait--;
            end else begin
                if (m_step == 0)       m_c = m_tgt;
                else if (m_tgt > m_c)  m_c = (m_c + m_step > m_tgt) ? m_tgt : m_c + m_step;
                else                   m_c = (m_c - m_step < m_tgt) ? m_tgt : m_c - m_step;
                m_wait = m_div;
                if (m_c == m_tgt) begin
                    m_ramp = 0;
                    m_done = 1;
                end
            end
        end
        #1;
        check_output("pwm_c", pwm_c, m_c);
        check_output("busy", busy, m_ramp);
        check_output("cfg_ready", cfg_ready, !m_ramp);
        check_output("done", done, m_done);
        if (done) done_cnt++;
        if (int'(pwm_c) != prev_c) begin
            chg_val.push_back(pwm_c);
            chg_time.push_back(cycle);
            prev_c = pwm_c;
        end
    end

    task automatic tick();
        @(negedge pwm_clk);
        #1;
    endtask

    task automatic apply_stimulus(input int target, input int step, input int div);
        int k = 0;
        while (!cfg_ready && k < 5000) begin
            tick();
            k++;
        end
        check_output("ready_before_request", cfg_ready, 1);
        cfg_valid  = 1'b1;
        cfg_target = 8'(target);
        cfg_step   = 8'(step);
        cfg_div    = 8'(div);
        tick();
        cfg_valid  = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        while (busy && k < budget) begin
            tick();
            k++;
        end
        check_output(name, busy, 0);
        tick();
    endtask

    task automatic clear_log();
        chg_val.delete();
        chg_time.delete();
    endtask

    initial begin
        int d0;
        int hold;
        int k;

        repeat (3) tick();
        check_output("reset_pwm_c", pwm_c, 0);
        check_output("reset_busy", busy, 0);
        check_output("reset_done", done, 0);
        check_output("reset_ready", cfg_ready, 1);
        pwm_resetn = 1'b1;
        repeat (2) tick();

        $display("[TB] up ramp 0 -> 10 step 4");
        clear_log();
        d0 = done_cnt;
        apply_stimulus(10, 4, 0);
        wait_idle("up_timeout", 2000);
        check_output("up_changes", chg_val.size(), 3);
        if (chg_val.size() >= 3) begin
            check_output("up_val0", chg_val[0], 4);
            check_output("up_val1", chg_val[1], 8);
            check_output("up_val2", chg_val[2], 10);
            check_output("up_spacing", chg_time[2] - chg_time[1], 256);
        end
        check_output("up_done_pulses", done_cnt - d0, 1);

        $display("[TB] down ramp 10 -> 0 step 3");
        clear_log();
        d0 = done_cnt;
        apply_stimulus(0, 3, 0);
        wait_idle("down_timeout", 2000);
        check_output("down_changes", chg_val.size(), 4);
        if (chg_val.size() >= 4) begin
            check_output("down_val0", chg_val[0], 7);
            check_output("down_val1", chg_val[1], 4);
            check_output("down_val2", chg_val[2], 1);
            check_output("down_val3", chg_val[3], 0);
        end
        check_output("down_done_pulses", done_cnt - d0, 1);

        $display("[TB] divider ramp 0 -> 6 step 2 div 2");
        clear_log();
        apply_stimulus(6, 2, 2);
        cfg_valid  = 1'b1;
        cfg_target = 8'd99;
        cfg_step   = 8'd1;
        cfg_div    = 8'd0;
        for (int i = 0; i < 50; i++) begin
            if (i % 10 == 0) check_output("ramp_ready_low", cfg_ready, 0);
            tick();
        end
        cfg_valid = 1'b0;
        wait_idle("div_timeout", 4000);
        check_output("div_changes", chg_val.size(), 3);
        if (chg_val.size() >= 3) begin
            check_output("div_val0", chg_val[0], 2);
            check_output("div_val2", chg_val[2], 6);
            check_output("div_spacing01", chg_time[1] - chg_time[0], 768);
            check_output("div_spacing12", chg_time[2] - chg_time[1], 768);
        end

        $display("[TB] jump request step 0 target 200");
        clear_log();
        apply_stimulus(200, 0, 0);
        wait_idle("jump_timeout", 600);
        check_output("jump_changes", chg_val.size(), 1);
        if (chg_val.size() >= 1) check_output("jump_val", chg_val[0], 200);

        $display("[TB] request equal to current compare");
        clear_log();
        d0 = done_cnt;
        apply_stimulus(200, 5, 0);
        check_output("same_done_now", done, 1);
        check_output("same_busy", busy, 0);
        tick();
        check_output("same_done_after", done, 0);
        check_output("same_changes", chg_val.size(), 0);
        check_output("same_done_pulses", done_cnt - d0, 1);

        $display("[TB] abort on a period-end update cycle");
        clear_log();
        d0 = done_cnt;
        apply_stimulus(100, 10, 0);
        k = 0;
        while (chg_val.size() < 1 && k < 600) begin
            tick();
            k++;
        end
        check_output("abort_first_update", chg_val.size(), 1);
        k = 0;
        while (pwm_i != 8'hFF && k < 600) begin
            tick();
            k++;
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_output("abort_busy", busy, 0);
        check_output("abort_held", pwm_c, 190);
        repeat (300) tick();
        check_output("abort_still_held", pwm_c, 190);
        check_output("abort_no_done", done_cnt - d0, 0);
        check_output("abort_changes", chg_val.size(), 1);

        $display("[TB] randomized ramps");
        for (int r = 0; r < 6; r++) begin
            apply_stimulus($urandom_range(0, 255), $urandom_range(32, 255), $urandom_range(0, 1));
            if (r % 2 == 1) begin
                hold = $urandom_range(10, 1500);
                repeat (hold) tick();
                abort = 1'b1;
                tick();
                abort = 1'b0;
            end
            wait_idle("rand_timeout", 6000);
            repeat ($urandom_range(1, 20)) tick();
        end

        $display("[TB] reset in the middle of a ramp");
        apply_stimulus((pwm_c > 8'd128) ? 0 : 255, 40, 0);
        repeat (300) tick();
        check_output("midramp_busy", busy, 1);
        @(negedge pwm_clk);
        #3;
        pwm_resetn = 1'b0;
        #1;
        check_output("async_reset_pwm_c", pwm_c, 0);
        check_output("async_reset_busy", busy, 0);
        check_output("async_reset_ready", cfg_ready, 1);
        check_output("async_reset_done", done, 0);
        repeat (2) tick();
        pwm_resetn = 1'b1;
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_ramp_ctrl.md
# pwm_ramp_ctrl

Duty-cycle ramp sequencer for the PWM peripheral. It owns the PWM compare value and moves it from its current value toward a programmed target in fixed steps. Updates happen only at PWM period boundaries, so the output never glitches mid-period. It sits in the pwm_clk domain between the (already synchronised) configuration source and the PWM counter/comparator.

## Interface
Parameters:
- pwm_width, 8, width of PWM counter, compare and step values
- div_width, 8, width of the period divider (periods per step)

Ports:
- pwm_clk  in  1  PWM clock; all logic on rising edge
- pwm_resetn  in  1  asynchronous, active-low reset
- cfg_valid  in  1  ramp request valid
- cfg_ready  out  1  request accepted when cfg_valid && cfg_ready
- cfg_target  in  pwm_width  final compare value
- cfg_step  in  pwm_width  compare increment/decrement per step; 0 = jump
- cfg_div  in  div_width  step taken every cfg_div+1 period ends
- abort  in  1  stop ramp, hold current compare
- pwm_i  in  pwm_width  PWM counter value; period end when pwm_i == all ones
- pwm_c  out  pwm_width  compare value driven to comparator
- busy  out  1  ramp in progress
- done  out  1  one-cycle pulse when pwm_c reaches target

## Operation
- States: IDLE, RAMP.
- IDLE:
  - cfg_ready = 1.
  - On handshake, latch target, step and div; load div_cnt = cfg_div.
  - If cfg_target == pwm_c: stay IDLE and pulse done next cycle.
  - Otherwise go to RAMP.
- RAMP: cfg_ready = 0, busy = 1; requests are not accepted.
  - On each cycle with pwm_i == max and div_cnt != 0: div_cnt decrements.
  - On pwm_i == max with div_cnt == 0: compare updates and div_cnt reloads.
- Update rule, computed in pwm_width+1 bits with no wrap:
  - Up (target > pwm_c): pwm_c = (target − pwm_c ≤ step) ? target : pwm_c + step.
  - Down: pwm_c = (pwm_c − target ≤ step) ? target : pwm_c − step.
  - step == 0: pwm_c = target.
- When the updated value equals target: go to IDLE and pulse done.
- abort in RAMP: go to IDLE, pwm_c held, no done. abort in IDLE is ignored.
- abort coinciding with an update cycle: abort wins and no update occurs.
- pwm_c never overshoots target and never wraps past 0 or max.

## Timing
- Reset values: pwm_c = 0, state IDLE, div_cnt = 0, busy = 0, done = 0. cfg_ready = 1 after reset.
- cfg_ready and busy are decoded combinationally from state.
- pwm_c is registered. An update decided in the cycle where pwm_i == max is visible in the next cycle (pwm_i == 0), i.e. it takes effect for the whole next period.
- done is registered and asserts in the same cycle as the final pwm_c value. busy deasserts in that same cycle.
- Minimum spacing between updates: (cfg_div+1) × 2^pwm_width cycles.
- First update: at the first period end at or after the handshake cycle + 1, plus cfg_div further period ends.
- A new request is accepted one cycle after done or after an abort.
- Reset mid-ramp: immediately returns to the reset values. pwm_c = 0 takes effect asynchronously.

## Structure
- pwm_pkg holds:
  - the state enum typedef,
  - the period-end constant (all ones of pwm_width),
  - PWM_C_R and the other PWM register offsets.
- One sub-module: pwm_step_calc, purely combinational.
  - Inputs: current, target, step.
  - Outputs: next value and reached flag, with saturation as above.
- Top level contains the FSM, div_cnt and the pwm_c register.

## Test plan
Defaults: pwm_width = 8, div_width = 8, free-running pwm_i.
- Reset: pwm_resetn low → pwm_c = 0, busy = 0, done = 0, cfg_ready = 1.
- Up ramp: target = 10, step = 4, div = 0 → pwm_c = 4, 8, 10 on three successive cycles with pwm_i == 0; done pulses once with 10; busy then drops.
- Down ramp: from 10, target = 0, step = 3, div = 0 → 7, 4, 1, 0, then done.
- Divider: target = 6, step = 2, div = 2 → updates on the 3rd, 6th and 9th period ends only. cfg_valid during RAMP is not accepted (cfg_ready = 0).
- Edge requests:
  - step = 0, target = 200 → single update to 200 at the first period end, then done.
  - target equal to current pwm_c → done next cycle, no change in pwm_c.
- Abort and reset: abort during the same cycle as pwm_i == 255 → no update, IDLE, no done, pwm_c held. Separately, pwm_resetn asserted mid-ramp → pwm_c = 0 and IDLE immediately.
